// File: rtl/pool2d_pkg.sv
// pool2d_pkg: FSM states, reduction-mode encodings and elaboration-time sizing
// helpers shared by pool2d_engine and pool2d_reduce.
package pool2d_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACC   = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam logic POOL_MAX = 1'b0;
  localparam logic POOL_AVG = 1'b1;

  // Ceiling log2; clog2(1) == 0.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // Width for a counter or index over n values, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

endpackage

// File: rtl/pool2d_reduce.sv
// pool2d_reduce: window accumulator for pool2d_engine. Folds one element per
// enabled cycle into a running max or sum and presents the reduced window.
// Build option POOL2D_AVG_EN: when defined, a widened sum accumulator and a
// constant divider are compiled in and mode_i selects max or average; when
// undefined, only the max path exists and mode_i is ignored.
module pool2d_reduce
  import pool2d_pkg::*;
#(
  parameter int DATA_WIDTH = 4,
  parameter int NELEM      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear_i,
  input  logic                  acc_en_i,
  input  logic                  mode_i,
  input  logic [DATA_WIDTH-1:0] elem_i,
  output logic [DATA_WIDTH-1:0] result_o
);

`ifdef POOL2D_AVG_EN
  // Sum of NELEM elements needs clog2(NELEM) extra bits, so it never wraps.
  localparam int AW = DATA_WIDTH + clog2(NELEM);
`else
  localparam int AW = DATA_WIDTH;
`endif

  logic [AW-1:0] acc_q, acc_d, elem_ext;

  assign elem_ext = AW'(elem_i);

  // Next accumulator value: clear for a new window, fold one element, or hold.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    acc_d = acc_q;
    if (clear_i) begin
      acc_d = '0;
    end else if (acc_en_i) begin
`ifdef POOL2D_AVG_EN
      if (mode_i == POOL_AVG) acc_d = acc_q + elem_ext;
      else if (elem_ext > acc_q) acc_d = elem_ext;
`else
      if (elem_ext > acc_q) acc_d = elem_ext;
`endif
    end
  end

  // Accumulator register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst) acc_q <= '0;
    else     acc_q <= acc_d;
  end

`ifdef POOL2D_AVG_EN
  // Reduced window value; average is the floored quotient by the window area.
  always_comb begin
    result_o = DATA_WIDTH'(acc_q);
    if (mode_i == POOL_AVG) result_o = DATA_WIDTH'(acc_q / AW'(NELEM));
  end
`else
  assign result_o = acc_q;

  // Max-only build: the mode bit has no effect.
  logic unused_mode;
  assign unused_mode = (mode_i == POOL_AVG);
`endif

endmodule

// File: rtl/pool2d_engine.sv
// pool2d_engine: multi-channel KxK / stride-S pooling over a captured flat
// C x H x W map, one window element per clock, max or average reduction.
// Build option POOL2D_AVG_EN enables the average path inside pool2d_reduce;
// without it mode is ignored and every run is max pooling with unchanged timing.
module pool2d_engine
  import pool2d_pkg::*;
#(
  parameter int H          = 3,
  parameter int W          = 4,
  parameter int C          = 1,
  parameter int POOL_SIZE  = 2,
  parameter int S          = 1,
  parameter int DATA_WIDTH = 4
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    start,
  input  logic                                    mode,
  input  logic [0:DATA_WIDTH*C*H*W-1]             input_data,
  output logic [0:DATA_WIDTH*C*((H-POOL_SIZE)/S+1)*((W-POOL_SIZE)/S+1)-1] output_data,
  output logic                                    busy,
  output logic                                    done
);

  localparam int K        = POOL_SIZE;
  localparam int OUTPUT_H = (H - K) / S + 1;
  localparam int OUTPUT_W = (W - K) / S + 1;
  localparam int NWIN     = C * OUTPUT_H * OUTPUT_W;
  localparam int IN_BITS  = DATA_WIDTH * C * H * W;
  localparam int OUT_BITS = DATA_WIDTH * NWIN;

  localparam int KW  = cnt_width(K);
  localparam int CW  = cnt_width(C);
  localparam int HW  = cnt_width(OUTPUT_H);
  localparam int WW  = cnt_width(OUTPUT_W);
  localparam int IBW = cnt_width(IN_BITS);
  localparam int OBW = cnt_width(OUT_BITS);

  localparam logic [KW-1:0] K_LAST = KW'(K - 1);
  localparam logic [CW-1:0] C_LAST = CW'(C - 1);
  localparam logic [HW-1:0] I_LAST = HW'(OUTPUT_H - 1);
  localparam logic [WW-1:0] J_LAST = WW'(OUTPUT_W - 1);

  state_e state_q, state_d;
  logic [KW-1:0] kx_q, kx_d, ky_q, ky_d;
  logic [WW-1:0] j_q, j_d;
  logic [HW-1:0] i_q, i_d;
  logic [CW-1:0] c_q, c_d;
  logic          mode_q;
  logic [0:IN_BITS-1]  data_q;
  logic [0:OUT_BITS-1] out_q;

  logic capture, acc_clear, acc_en, write_en;
  logic [DATA_WIDTH-1:0] elem, result;

  int elem_idx, win_idx;
  logic [IBW-1:0] elem_bit;
  logic [OBW-1:0] win_bit;

  // Element (c, i*S+ky, j*S+kx) and output slot (c, i, j), element 0 at the MSB end.
  assign elem_idx = (int'(c_q) * H + int'(i_q) * S + int'(ky_q)) * W + int'(j_q) * S + int'(kx_q);
  assign win_idx  = (int'(c_q) * OUTPUT_H + int'(i_q)) * OUTPUT_W + int'(j_q);
  assign elem_bit = IBW'(elem_idx * DATA_WIDTH);
  assign win_bit  = OBW'(win_idx * DATA_WIDTH);
  assign elem     = data_q[elem_bit +: DATA_WIDTH];

  // Next state and scan counters; kx fastest, then ky, j, i, c.
  always_comb begin
    state_d   = state_q;
    kx_d      = kx_q;
    ky_d      = ky_q;
    j_d       = j_q;
    i_d       = i_q;
    c_d       = c_q;
    capture   = 1'b0;
    acc_clear = 1'b0;
    acc_en    = 1'b0;
    write_en  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          capture   = 1'b1;
          acc_clear = 1'b1;
          kx_d      = '0;
          ky_d      = '0;
          j_d       = '0;
          i_d       = '0;
          c_d       = '0;
          state_d   = ACC;
        end
      end
      ACC: begin
        acc_en = 1'b1;
        if (kx_q != K_LAST) begin
          kx_d = kx_q + 1'b1;
        end else begin
          kx_d = '0;
          if (ky_q != K_LAST) begin
            ky_d = ky_q + 1'b1;
          end else begin
            ky_d    = '0;
            state_d = WRITE;
          end
        end
      end
      WRITE: begin
        write_en  = 1'b1;
        acc_clear = 1'b1;
        state_d   = ACC;
        if (j_q != J_LAST) begin
          j_d = j_q + 1'b1;
        end else begin
          j_d = '0;
          if (i_q != I_LAST) begin
            i_d = i_q + 1'b1;
          end else begin
            i_d = '0;
            if (c_q != C_LAST) begin
              c_d = c_q + 1'b1;
            end else begin
              c_d     = '0;
              state_d = DONE;
            end
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, counters, captured mode and the output map; reset aborts any run.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      kx_q    <= '0;
      ky_q    <= '0;
      j_q     <= '0;
      i_q     <= '0;
      c_q     <= '0;
      mode_q  <= POOL_MAX;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      kx_q    <= kx_d;
      ky_q    <= ky_d;
      j_q     <= j_d;
      i_q     <= i_d;
      c_q     <= c_d;
      if (capture)  mode_q <= mode;
      if (write_en) out_q[win_bit +: DATA_WIDTH] <= result;
    end
  end

  // Input snapshot taken on the accepting edge and used for the whole run.
  always_ff @(posedge clk) begin
    // NOTE: the capture register is deliberately not reset; it is only read after a capture.
    if (capture) data_q <= input_data;
  end

  pool2d_reduce #(
    .DATA_WIDTH (DATA_WIDTH),
    .NELEM      (K * K)
  ) u_reduce (
    .clk      (clk),
    .rst      (rst),
    .clear_i  (acc_clear),
    .acc_en_i (acc_en),
    .mode_i   (mode_q),
    .elem_i   (elem),
    .result_o (result)
  );

  assign output_data = out_q;
  assign busy        = (state_q == ACC) || (state_q == WRITE);
  assign done        = (state_q == DONE);

endmodule

// File: tb/tb_pool2d_engine.sv
// tb_pool2d_engine: scoreboard bench for pool2d_engine. Two instances: the
// default 1x3x4 K=2 S=1 map and a 2x4x4 K=2 S=2 map. Drivers push expected
// results and done cycles; monitors compare whenever done pulses.
module tb_pool2d_engine;

  localparam int DW = 4;

  localparam int A_H = 3, A_W = 4, A_C = 1, A_K = 2, A_S = 1;
  localparam int A_NWIN = A_C * ((A_H - A_K) / A_S + 1) * ((A_W - A_K) / A_S + 1);
  localparam int A_NIN  = A_C * A_H * A_W;
  localparam int A_LAT  = A_NWIN * (A_K * A_K + 1);

  localparam int B_H = 4, B_W = 4, B_C = 2, B_K = 2, B_S = 2;
  localparam int B_NWIN = B_C * ((B_H - B_K) / B_S + 1) * ((B_W - B_K) / B_S + 1);
  localparam int B_NIN  = B_C * B_H * B_W;
  localparam int B_LAT  = B_NWIN * (B_K * B_K + 1);

`ifdef POOL2D_AVG_EN
  localparam bit AVG_BUILT = 1'b1;
`else
  localparam bit AVG_BUILT = 1'b0;
`endif

  typedef int int_q_t[$];
  typedef struct {
    logic [63:0] data;
    int          e0;
  } exp_t;

  exp_t exp_a[$];
  exp_t exp_b[$];
  exp_t it_a, it_b;
  int   checks   = 0;
  int   failures = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic                 rst_a, start_a, mode_a, busy_a, done_a;
  logic [0:A_NIN*DW-1]  in_a;
  logic [0:A_NWIN*DW-1] out_a;
  logic                 rst_b, start_b, mode_b, busy_b, done_b;
  logic [0:B_NIN*DW-1]  in_b;
  logic [0:B_NWIN*DW-1] out_b;
  bit                   busy_ok_a = 1'b1;
  bit                   busy_ok_b = 1'b1;

  pool2d_engine #(
    .H(A_H), .W(A_W), .C(A_C), .POOL_SIZE(A_K), .S(A_S), .DATA_WIDTH(DW)
  ) dut_a (
    .clk(clk), .rst(rst_a), .start(start_a), .mode(mode_a),
    .input_data(in_a), .output_data(out_a), .busy(busy_a), .done(done_a)
  );

  pool2d_engine #(
    .H(B_H), .W(B_W), .C(B_C), .POOL_SIZE(B_K), .S(B_S), .DATA_WIDTH(DW)
  ) dut_b (
    .clk(clk), .rst(rst_b), .start(start_b), .mode(mode_b),
    .input_data(in_b), .output_data(out_b), .busy(busy_b), .done(done_b)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, want);
    end
  endtask

  // Reference pooling: plain loops over channels, output rows/cols and the window.
  function automatic int_q_t ref_pool(input int h, input int w, input int c, input int k,
                                      input int s, input logic avg, input int_q_t px);
    int_q_t res;
    int oh, ow, v, best, sum;
    oh = (h - k) / s + 1;
    ow = (w - k) / s + 1;
    for (int ch = 0; ch < c; ch++)
      for (int i = 0; i < oh; i++)
        for (int j = 0; j < ow; j++) begin
          best = 0;
          sum  = 0;
          for (int ky = 0; ky < k; ky++)
            for (int kx = 0; kx < k; kx++) begin
              v = px[(ch * h + i * s + ky) * w + j * s + kx];
              sum += v;
              if (v > best) best = v;
            end
          res.push_back(avg ? sum / (k * k) : best);
        end
    return res;
  endfunction

  // Concatenate values MSB-first: element 0 ends up most significant.
  function automatic logic [127:0] pack(input int_q_t vals);
    logic [127:0] r;
    r = '0;
    foreach (vals[n]) r = (r << DW) | 128'(vals[n] & ((1 << DW) - 1));
    return r;
  endfunction

  function automatic logic eff_mode(input logic md);
    return md & AVG_BUILT;
  endfunction

  task automatic issue_a(input int_q_t px, input logic md, input logic [63:0] want);
    logic [127:0] pv;
    pv = pack(px);
    @(negedge clk);
    in_a    = pv[A_NIN*DW-1:0];
    mode_a  = md;
    start_a = 1'b1;
    exp_a.push_back('{data: want, e0: cyc + 1});
    @(negedge clk);
    start_a = 1'b0;
    mode_a  = ~md;
    pv      = {$urandom(), $urandom(), $urandom(), $urandom()};
    in_a    = pv[A_NIN*DW-1:0];
  endtask

  task automatic issue_b(input int_q_t px, input logic md, input logic [63:0] want);
    logic [127:0] pv;
    pv = pack(px);
    @(negedge clk);
    in_b    = pv[B_NIN*DW-1:0];
    mode_b  = md;
    start_b = 1'b1;
    exp_b.push_back('{data: want, e0: cyc + 1});
    @(negedge clk);
    start_b = 1'b0;
    mode_b  = ~md;
    pv      = {$urandom(), $urandom(), $urandom(), $urandom()};
    in_b    = pv[B_NIN*DW-1:0];
  endtask

  task automatic drain_a();
    int n;
    n = 0;
    while (exp_a.size() != 0 && n < 2 * A_LAT + 20) begin
      @(negedge clk);
      n++;
    end
    if (exp_a.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL a_timeout: %0d run(s) pending after %0d cycles, required 0", exp_a.size(), n);
      exp_a.delete();
    end
    @(negedge clk);
  endtask

  task automatic drain_b();
    int n;
    n = 0;
    while (exp_b.size() != 0 && n < 2 * B_LAT + 20) begin
      @(negedge clk);
      n++;
    end
    if (exp_b.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL b_timeout: %0d run(s) pending after %0d cycles, required 0", exp_b.size(), n);
      exp_b.delete();
    end
    @(negedge clk);
  endtask

  // Monitor A: busy must stay high during each run; compare data and timing on done.
  always @(negedge clk) begin
    if (rst_a) begin
      busy_ok_a = 1'b1;
    end else begin
      if (exp_a.size() != 0)
        if (cyc >= exp_a[0].e0 && cyc < exp_a[0].e0 + A_LAT && busy_a !== 1'b1) busy_ok_a = 1'b0;
      if (done_a === 1'b1) begin
        if (exp_a.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL a_done_unexpected: done pulsed at cycle %0d, required no pulse", cyc);
        end else begin
          it_a = exp_a.pop_front();
          check("a_data", 64'(out_a), it_a.data);
          check("a_done_cycle", 64'(cyc), 64'(it_a.e0 + A_LAT));
          check("a_busy_during_run", 64'(busy_ok_a), 64'd1);
          check("a_busy_low_at_done", 64'(busy_a), 64'd0);
          busy_ok_a = 1'b1;
        end
      end
    end
  end

  // Monitor B: same checks for the two-channel instance.
  always @(negedge clk) begin
    if (rst_b) begin
      busy_ok_b = 1'b1;
    end else begin
      if (exp_b.size() != 0)
        if (cyc >= exp_b[0].e0 && cyc < exp_b[0].e0 + B_LAT && busy_b !== 1'b1) busy_ok_b = 1'b0;
      if (done_b === 1'b1) begin
        if (exp_b.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL b_done_unexpected: done pulsed at cycle %0d, required no pulse", cyc);
        end else begin
          it_b = exp_b.pop_front();
          check("b_data", 64'(out_b), it_b.data);
          check("b_done_cycle", 64'(cyc), 64'(it_b.e0 + B_LAT));
          check("b_busy_during_run", 64'(busy_ok_b), 64'd1);
          check("b_busy_low_at_done", 64'(busy_b), 64'd0);
          busy_ok_b = 1'b1;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before the summary");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int_q_t s1, max1, avg1, b_dir, b_max, b_avg, px;
    logic [127:0] pv;
    logic [63:0] want_max1, want_mode1, want;
    int e0;
    logic md;

    rst_a = 1'b1; start_a = 1'b0; mode_a = 1'b0; in_a = '0;
    rst_b = 1'b1; start_b = 1'b0; mode_b = 1'b0; in_b = '0;
    repeat (3) @(negedge clk);
    check("a_reset_out",  64'(out_a),  64'd0);
    check("a_reset_busy", 64'(busy_a), 64'd0);
    check("a_reset_done", 64'(done_a), 64'd0);
    check("b_reset_out",  64'(out_b),  64'd0);
    check("b_reset_busy", 64'(busy_b), 64'd0);
    check("b_reset_done", 64'(done_b), 64'd0);
    rst_a = 1'b0;
    rst_b = 1'b0;

    s1   = '{1, 2, 3, 4, 6, 5, 6, 5, 7, 8, 9, 5};
    max1 = '{6, 6, 6, 8, 9, 9};
    avg1 = '{3, 4, 4, 6, 7, 6};
    pv = pack(max1);
    want_max1 = pv[63:0];
    if (AVG_BUILT) pv = pack(avg1);
    want_mode1 = pv[63:0];

    // Directed max, then mode=1 (average, or max when the average path is absent).
    issue_a(s1, 1'b0, want_max1);
    drain_a();
    issue_a(s1, 1'b1, want_mode1);
    drain_a();

    // start pulsed mid-run with other data and mode must be ignored.
    issue_a(s1, 1'b1, want_mode1);
    e0 = exp_a[$].e0;
    while (cyc < e0 + 7) @(negedge clk);
    start_a = 1'b1;
    mode_a  = 1'b0;
    pv      = {$urandom(), $urandom(), $urandom(), $urandom()};
    in_a    = pv[A_NIN*DW-1:0];
    @(negedge clk);
    start_a = 1'b0;
    drain_a();
    repeat (A_LAT) @(negedge clk);

    // start held through DONE: second run accepted on the first IDLE cycle.
    pv = pack(s1);
    @(negedge clk);
    in_a    = pv[A_NIN*DW-1:0];
    mode_a  = 1'b0;
    start_a = 1'b1;
    e0 = cyc + 1;
    exp_a.push_back('{data: want_max1, e0: e0});
    exp_a.push_back('{data: want_max1, e0: e0 + A_LAT + 2});
    while (cyc < e0 + A_LAT + 2) @(negedge clk);
    start_a = 1'b0;
    drain_a();

    // Reset 12 cycles into a run aborts it; a fresh run then completes.
    issue_a(s1, 1'b0, want_max1);
    e0 = exp_a[$].e0;
    while (cyc < e0 + 11) @(negedge clk);
    exp_a.delete();
    rst_a = 1'b1;
    @(negedge clk);
    check("a_midrun_reset_out",  64'(out_a),  64'd0);
    check("a_midrun_reset_busy", 64'(busy_a), 64'd0);
    check("a_midrun_reset_done", 64'(done_a), 64'd0);
    rst_a = 1'b0;
    issue_a(s1, 1'b1, want_mode1);
    drain_a();

    // Random maps and modes on the default instance.
    repeat (8) begin
      px.delete();
      for (int n = 0; n < A_NIN; n++) px.push_back(int'($urandom_range(0, (1 << DW) - 1)));
      md = 1'($urandom_range(0, 1));
      pv = pack(ref_pool(A_H, A_W, A_C, A_K, A_S, eff_mode(md), px));
      want = pv[63:0];
      issue_a(px, md, want);
      drain_a();
    end

    // Two channels: ramp 0..15 and all-15 (checks the sum does not overflow).
    b_dir.delete();
    for (int n = 0; n < 16; n++) b_dir.push_back(n);
    for (int n = 0; n < 16; n++) b_dir.push_back(15);
    b_max = '{5, 7, 13, 15, 15, 15, 15, 15};
    b_avg = '{2, 4, 10, 12, 15, 15, 15, 15};
    pv = pack(b_max);
    want = pv[63:0];
    issue_b(b_dir, 1'b0, want);
    drain_b();
    if (AVG_BUILT) pv = pack(b_avg);
    want = pv[63:0];
    issue_b(b_dir, 1'b1, want);
    drain_b();

    repeat (6) begin
      px.delete();
      for (int n = 0; n < B_NIN; n++) px.push_back(int'($urandom_range(0, (1 << DW) - 1)));
      md = 1'($urandom_range(0, 1));
      pv = pack(ref_pool(B_H, B_W, B_C, B_K, B_S, eff_mode(md), px));
      want = pv[63:0];
      issue_b(px, md, want);
      drain_b();
    end

    repeat (10) @(negedge clk);
    check("a_pending_at_end", 64'(exp_a.size()), 64'd0);
    check("b_pending_at_end", 64'(exp_b.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pool2d_engine.md
# pool2d_engine

Multi-channel, multi-mode successor to the single-channel max-pooling block in the pooling verification suite. Given a flat C×H×W feature map, it produces a C×OUTPUT_H×OUTPUT_W pooled map using either max or average reduction.
- The window size K and stride S are parameters.
- One window element is reduced per clock through a sequential scan engine.
- It sits between the convolution outputs and the next layer under verification.
- It uses the same flat-bus start/done interface as the rest of the operator suite.

## Interface
Parameters:
- H, 3: input rows
- W, 4: input columns
- C, 1: channel count
- POOL_SIZE, 2: window edge K; window is K×K; require 1 ≤ K ≤ min(H,W)
- S, 1: stride, ≥ 1
- DATA_WIDTH, 4: unsigned element width
- OUTPUT_H, derived (H−K)/S+1; OUTPUT_W, derived (W−K)/S+1; NWIN, derived C·OUTPUT_H·OUTPUT_W

Ports:
- clk  in  1  single clock; everything is on the rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  request; sampled only in IDLE
- mode  in  1  0 = max, 1 = average; sampled with start
- input_data  in  DATA_WIDTH·C·H·W  flat input map, declared [0:N−1]
- output_data  out  DATA_WIDTH·NWIN  flat output map, declared [0:N−1], registered
- busy  out  1  high from the accepting edge until DONE is entered
- done  out  1  one-cycle completion pulse

## Operation
- Element addressing:
  - Element (c,r,x) occupies index ((c·H+r)·W+x)·DATA_WIDTH +: DATA_WIDTH, so element 0 is at the MSB end.
  - Output (c,i,j) uses the same rule with OUTPUT_H and OUTPUT_W.
- FSM states:
  - IDLE: idle state.
    - With start=1, capture input_data and mode into internal registers, clear the accumulator, set the window and element counters to 0, and go to ACC.
  - ACC: read captured element (c, i·S+ky, j·S+kx) and fold it into the accumulator.
    - Max mode: keep the larger value, unsigned compare.
    - Average mode: add the element.
    - After the K·K-th element, go to WRITE.
  - WRITE: write the reduced value to output slot (c,i,j).
    - Average result = floor(sum / (K·K)). The sum register is DATA_WIDTH+clog2(K·K) bits, so it cannot overflow.
    - Then advance j, then i, then c. Go to ACC, or to DONE after window NWIN−1.
  - DONE: done=1 for this cycle only, then go to IDLE.
- The scan order is kx fastest, then ky, j, i, c.
- Captured data is used for the whole run. input_data may change freely after the accepting edge.
- start in ACC, WRITE or DONE is ignored; requests are not queued. start held high through DONE is accepted on the first IDLE cycle.
- output_data:
  - Updates slot-by-slot during a run.
  - Holds its values from done until the next WRITE.
  - Slots are not cleared at start.
- Reset:
  - Reset values: output_data=0, busy=0, done=0, state IDLE.
  - Reset mid-run aborts with no partial done.
  - rst has priority over start in the same cycle.

## Timing
- Accepting edge E0 is the edge at which start=1 is seen in IDLE; busy rises after it.
- Each window takes K·K ACC cycles plus 1 WRITE cycle.
- done is high in the cycle after edge E0+NWIN·(K·K+1). On that same edge busy falls.
- Total latency is NWIN·(K²+1) cycles. The default configuration takes 30 cycles.
- Back-to-back throughput: one run per NWIN·(K²+1)+2 cycles.

## Configuration
- POOL2D_AVG_EN defined:
  - The average path is compiled in: sum accumulator and constant divider.
  - mode selects the reduction.
- POOL2D_AVG_EN undefined:
  - Only the max path exists and mode is ignored (treated as 0).
  - The accumulator is DATA_WIDTH bits.
  - Timing is unchanged.

## Structure
- Package pool2d_pkg holds:
  - the state enum (IDLE, ACC, WRITE, DONE);
  - mode constants POOL_MAX=0 and POOL_AVG=1;
  - a clog2 helper function.
- Sub-module pool2d_reduce:
  - Owns the accumulator, with clear, accumulate and final-result ports.
  - Selects max or average internally.
  - The top level keeps the FSM, counters, capture register and output register.

## Test plan
1. Max, default parameters, mode=0.
   - Input rows: 1 2 3 4 / 6 5 6 5 / 7 8 9 5.
   - Expected output rows: 6 6 6 / 8 9 9.
   - done must pulse exactly 30 cycles after E0; busy must be high throughout.
2. Average, same input, mode=1, with POOL2D_AVG_EN defined.
   - Expected output rows: 3 4 4 / 6 7 6 (floor division).
3. Two channels, H=W=4, K=2, S=2, max mode, tested in both reductions.
   - Channel 0 = 0..15 row-major; expected output 5 7 13 15.
   - Channel 1 = all 15; expected output all 15 in both max and average modes (no overflow).
4. Handshake:
   - Pulse start again mid-run: the run is ignored and done is not duplicated.
   - Hold start high through DONE: a second run starts in the next IDLE cycle with the same results.
5. Reset mid-run:
   - Assert rst at cycle 12: next cycle output_data=0, busy=0, done=0.
   - A fresh start afterwards completes normally.
6. POOL2D_AVG_EN undefined, mode=1, input from scenario 1:
   - Output must be the max result 6 6 6 / 8 9 9 with 30-cycle latency.
